phy_mgmt_ctrl: RTL and testbench

PHY management controller for the Ethernet PHY behind the RGMII receive path. After reset it sequences `phy_rst_n` (hold, then settle time), then accepts register commands on a valid/ready interface. It serialises each command as an IEEE 802.3 Clause 22 MDIO frame on `mdc`/`mdio`, and returns read data on a one-cycle response strobe. It sits beside `rgmii` in the top level and drives the `mdc`, `mdio` and `phy_rst_n` pins.

---
 rtl/phy_mgmt_ctrl.sv | 148 ++++++++++++++
 tb/tb_phy_mgmt_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_mgmt_ctrl.sv
// Clause 22 MDIO management controller: sequences phy_rst_n after reset, then
// serialises register read/write commands onto mdc/mdio.
//
// state      | meaning
// RST_HOLD   | phy_rst_n held low for RST_CYCLES
// RST_WAIT   | PHY settling for POST_RST_CYCLES before init_done
// IDLE       | cmd_ready high, bus parked
// PREAMBLE   | 32 MDC cycles of ones
// FRAME      | 32 MDC cycles of ST/OP/PHYAD/REGAD/TA/DATA
module phy_mgmt_ctrl #(
  parameter int CLK_DIV         = 25,
  parameter int RST_CYCLES      = 1_000_000,
  parameter int POST_RST_CYCLES = 100_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        rd_error,
  output logic        init_done,
  output logic        phy_rst_n,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam logic [2:0] S_RST_HOLD = 3'd0;
  localparam logic [2:0] S_RST_WAIT = 3'd1;
  localparam logic [2:0] S_IDLE     = 3'd2;
  localparam logic [2:0] S_PREAMBLE = 3'd3;
  localparam logic [2:0] S_FRAME    = 3'd4;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  logic [2:0]       state;
  logic [31:0]      tmr;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      shreg;
  logic             is_write;
  logic [15:0]      rd_shift;
  logic             ta_err;

  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge sys_clk) begin
    rd_valid <= 1'b0;
    if (sys_rst) begin
      state     <= S_RST_HOLD;
      tmr       <= 32'(RST_CYCLES - 1);
      div_cnt   <= DIV_LOAD;
      bit_cnt   <= '0;
      shreg     <= '0;
      is_write  <= 1'b0;
      rd_shift  <= '0;
      ta_err    <= 1'b0;
      rd_data   <= '0;
      rd_error  <= 1'b0;
      init_done <= 1'b0;
      phy_rst_n <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
    end else begin
      case (state)
        S_RST_HOLD: begin
          if (tmr == '0) begin
            phy_rst_n <= 1'b1;
            tmr       <= 32'(POST_RST_CYCLES - 1);
            state     <= S_RST_WAIT;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_RST_WAIT: begin
          if (tmr == '0) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            // read frames carry ones in TA/DATA; the driver is released there anyway
            shreg    <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy_addr, cmd_reg_addr,
                         (cmd_write ? {2'b10, cmd_wdata} : 18'h3ffff)};
            is_write <= cmd_write;
            div_cnt  <= DIV_LOAD;
            bit_cnt  <= '0;
            mdc      <= 1'b0;
            mdio_o   <= 1'b1;
            mdio_oe  <= 1'b1;
            state    <= S_PREAMBLE;
          end
        end
        S_PREAMBLE, S_FRAME: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - DIV_W'(1);
          end else begin
            div_cnt <= DIV_LOAD;
            if (!mdc) begin
              mdc <= 1'b1;
              if (state == S_FRAME && !is_write) begin
                if (bit_cnt == 5'd15) ta_err <= mdio_i;
                if (bit_cnt >= 5'd16) rd_shift <= {rd_shift[14:0], mdio_i};
              end
            end else begin
              mdc     <= 1'b0;
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd31) begin
                if (state == S_PREAMBLE) begin
                  mdio_o  <= shreg[31];
                  mdio_oe <= 1'b1;
                  state   <= S_FRAME;
                end else begin
                  mdio_o  <= 1'b1;
                  mdio_oe <= 1'b0;
                  state   <= S_IDLE;
                  if (!is_write) begin
                    rd_valid <= 1'b1;
                    rd_data  <= rd_shift;
                    rd_error <= ta_err;
                  end
                end
              end else if (state == S_FRAME) begin
                // reads hand the bus to the PHY from the first TA bit (index 14)
                shreg   <= {shreg[30:0], 1'b0};
                mdio_o  <= shreg[30];
                mdio_oe <= is_write || (bit_cnt < 5'd13);
              end
            end
          end
        end
        default: state <= S_RST_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_mgmt_ctrl.sv
// Scoreboarded bench for phy_mgmt_ctrl with an MDIO PHY responder and a
// register-map reference model.
module tb_phy_mgmt_ctrl;
  localparam int CLK_DIV         = 2;
  localparam int RST_CYCLES      = 10;
  localparam int POST_RST_CYCLES = 5;
  localparam int FRAME_CYC       = 128 * CLK_DIV;
  localparam logic [4:0] ABSENT_PHY = 5'd31;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = '0;
  logic [4:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        mdio_i = 1'b1;
  logic        cmd_ready, rd_valid, rd_error, init_done, phy_rst_n, mdc, mdio_o, mdio_oe;
  logic [15:0] rd_data;

  phy_mgmt_ctrl #(
    .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES), .POST_RST_CYCLES(POST_RST_CYCLES)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rd_valid(rd_valid), .rd_data(rd_data), .rd_error(rd_error),
    .init_done(init_done), .phy_rst_n(phy_rst_n), .mdc(mdc), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic w; logic [4:0] phy; logic [4:0] regad; logic [15:0] data; int hs; } frame_t;
  typedef struct { logic [15:0] data; logic err; int hs; } rd_t;

  frame_t exp_frames[$];
  rd_t    exp_reads[$];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] dev_mem [0:1023];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int n_issued = 0;
  int n_reads  = 0;
  int n_frames_seen = 0;
  int n_rdv    = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // PHY responder and frame monitor, sampled 2 ns after each edge
  int k = 0;
  logic [63:0] got_o = '0, got_oe = '0;
  logic prev_mdc = 1'b0, rd_active = 1'b0, pend_end = 1'b0;
  logic [15:0] rd_word = '0;
  int end_exp = 0;

  always begin
    @(posedge sys_clk);
    #2;
    if (sys_rst) begin
      k = 0; got_o = '0; got_oe = '0; prev_mdc = 1'b0;
      rd_active = 1'b0; mdio_i = 1'b1; pend_end = 1'b0;
    end else begin
      if (mdc && !prev_mdc) begin
        got_o  = {got_o[62:0], mdio_o};
        got_oe = {got_oe[62:0], mdio_oe};
        if (k == 45) begin
          rd_active = (got_o[11:10] == 2'b10) && (got_o[9:5] != ABSENT_PHY);
          rd_word   = dev_mem[got_o[9:0]];
        end
        if (k >= 46 && rd_active) begin
          if (k - 32 == 14) mdio_i = 1'b0;
          else if (k - 32 <= 30) mdio_i = rd_word[30 - (k - 32)];
          else begin mdio_i = 1'b1; rd_active = 1'b0; end
        end
        if (k == 63) begin
          if (exp_frames.size() == 0) begin
            check("unexpected frame", 1, 0);
          end else begin
            frame_t e;
            logic [63:0] exp_o, mask;
            e = exp_frames.pop_front();
            exp_o = {32'hFFFF_FFFF, 2'b01, (e.w ? 2'b01 : 2'b10), e.phy, e.regad, 2'b10, e.data};
            mask  = e.w ? {64{1'b1}} : {{46{1'b1}}, 18'h0};
            check("frame mdio_o bits", got_o & mask, exp_o & mask);
            check("frame mdio_oe bits", got_oe, mask);
            pend_end = 1'b1;
            end_exp  = e.hs + FRAME_CYC;
          end
          if (got_o[29:28] == 2'b01 && got_o[27:23] != ABSENT_PHY)
            dev_mem[got_o[27:18]] = got_o[15:0];
          n_frames_seen++;
          k = 0;
        end else begin
          k++;
        end
      end
      if (!mdc && prev_mdc && pend_end) begin
        check("frame end cycle", 64'(cyc), 64'(end_exp));
        check("end mdio_oe/cmd_ready", {mdio_oe, cmd_ready}, 2'b01);
        pend_end = 1'b0;
      end
      prev_mdc = mdc;
    end
  end

  always begin
    @(posedge sys_clk);
    #2;
    if (!sys_rst && rd_valid) begin
      n_rdv++;
      if (exp_reads.size() == 0) begin
        check("unexpected rd_valid", 1, 0);
      end else begin
        rd_t r;
        r = exp_reads.pop_front();
        check("rd_data", rd_data, r.data);
        check("rd_error", rd_error, r.err);
        check("rd_valid cycle", 64'(cyc), 64'(r.hs + FRAME_CYC));
        check("cmd_ready with rd_valid", cmd_ready, 1);
      end
    end
  end

  task automatic do_reset_seq();
    int n = 0;
    logic early_ready = 1'b0;
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    @(posedge sys_clk);
    #1;
    check("reset outputs",
          {phy_rst_n, mdc, mdio_o, mdio_oe, cmd_ready, rd_valid, rd_error, init_done, rd_data},
          {8'b0010_0000, 16'h0000});
    sys_rst = 1'b0;
    while (!phy_rst_n && n < 4 * RST_CYCLES + 10) begin
      @(posedge sys_clk); #1; n++;
      early_ready = early_ready | cmd_ready;
    end
    check("phy_rst_n rise cycle", 64'(n), 64'(RST_CYCLES));
    while (!init_done && n < 4 * (RST_CYCLES + POST_RST_CYCLES) + 10) begin
      @(posedge sys_clk); #1; n++;
      if (!init_done) early_ready = early_ready | cmd_ready;
    end
    check("init_done rise cycle", 64'(n), 64'(RST_CYCLES + POST_RST_CYCLES));
    check("cmd_ready early", early_ready, 0);
    check("cmd_ready at init_done", cmd_ready, 1);
  endtask

  task automatic send_cmd(input logic w, input logic [4:0] phy, input logic [4:0] regad,
                          input logic [15:0] data, output int hs);
    int n = 0;
    frame_t f;
    rd_t r;
    cmd_valid = 1'b1; cmd_write = w; cmd_phy_addr = phy; cmd_reg_addr = regad; cmd_wdata = data;
    while (!cmd_ready && n < FRAME_CYC + 50) begin
      @(posedge sys_clk); #1; n++;
    end
    if (!cmd_ready) begin
      check("handshake timeout", 0, 1);
      cmd_valid = 1'b0;
      hs = -1;
      return;
    end
    @(posedge sys_clk);
    #1;
    hs = cyc;
    cmd_valid = 1'b0;
    n_issued++;
    f.w = w; f.phy = phy; f.regad = regad; f.data = data; f.hs = hs;
    exp_frames.push_back(f);
    if (w) begin
      if (phy != ABSENT_PHY) ref_mem[{phy, regad}] = data;
    end else begin
      n_reads++;
      r.data = (phy == ABSENT_PHY) ? 16'hFFFF : ref_mem[{phy, regad}];
      r.err  = (phy == ABSENT_PHY);
      r.hs   = hs;
      exp_reads.push_back(r);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_frames.size() != 0 || exp_reads.size() != 0) && n < 2 * FRAME_CYC + 50) begin
      @(posedge sys_clk); #1; n++;
    end
    check("drain timeout", (exp_frames.size() != 0 || exp_reads.size() != 0), 0);
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_a, hs_b, prev_hs, rdv_before;
    logic [4:0] phy;
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      ref_mem[i] = v;
      dev_mem[i] = v;
    end
    ref_mem[{5'd1, 5'd2}] = 16'h0141;
    dev_mem[{5'd1, 5'd2}] = 16'h0141;

    do_reset_seq();

    send_cmd(1'b1, 5'd1, 5'd0, 16'h1140, hs_a);
    wait_idle();
    send_cmd(1'b0, 5'd1, 5'd2, 16'h0000, hs_a);
    wait_idle();
    send_cmd(1'b1, 5'd2, 5'd3, 16'h5A3C, hs_a);
    wait_idle();
    check("rd_data held across write", rd_data, 16'h0141);
    send_cmd(1'b0, ABSENT_PHY, 5'd1, 16'h0000, hs_a);
    wait_idle();

    // two commands held back to back: second only lands one cycle after the first ends
    send_cmd(1'b1, 5'd3, 5'd4, 16'hA5A5, hs_a);
    send_cmd(1'b0, 5'd3, 5'd4, 16'h0000, hs_b);
    check("busy accept cycle", 64'(hs_b - hs_a), 64'(FRAME_CYC + 1));
    wait_idle();

    // abort a read during the low half of frame bit 20
    send_cmd(1'b0, 5'd1, 5'd2, 16'h0000, hs_a);
    repeat (104 * CLK_DIV) @(posedge sys_clk);
    #1;
    rdv_before = n_rdv;
    exp_frames.delete();
    exp_reads.delete();
    do_reset_seq();
    check("no rd_valid after abort", 64'(n_rdv), 64'(rdv_before));

    prev_hs = -1;
    for (int i = 0; i < 24; i++) begin
      int pick, gap;
      pick = $urandom_range(0, 3);
      phy  = (pick == 3) ? ABSENT_PHY : 5'(pick);
      gap  = $urandom_range(0, 2);
      repeat (gap) @(posedge sys_clk);
      #1;
      send_cmd(1'($urandom_range(0, 1)), phy, 5'($urandom_range(0, 3)), 16'($urandom), hs_a);
      if (prev_hs >= 0) check("back-to-back accept cycle", 64'(hs_a - prev_hs), 64'(FRAME_CYC + 1));
      prev_hs = hs_a;
    end
    wait_idle();

    check("frames observed", 64'(n_frames_seen), 64'(n_issued - 1));
    check("read responses observed", 64'(n_rdv), 64'(n_reads - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
